// File: rtl/lcm_add_seq.sv
// Sequential LCM engine: two accumulators step by their base operand until they meet.
// Latency: start edge to done = LCM/A + LCM/B + 1 edges (2 edges when either operand is 0).
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while busy.
//
// Optional feature macro: LCM_ITER_COUNT_EN adds the iter_cnt addition-step counter port.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      begin a load (A on this cycle's data_in, B on the next)
//   data_in    W-bit operand bus shared by A and B
//   busy       high while loading B or iterating
//   done       high when result is valid
//   result     2*W-bit LCM(A,B), 0 if either operand is 0
//   iter_cnt   number of additions performed (LCM_ITER_COUNT_EN only)
module lcm_add_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   data_in,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result
`ifdef LCM_ITER_COUNT_EN
  ,
  output logic [2*W-1:0] iter_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOADB = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [W-1:0] ZERO_HI = '0;

  state_t         state;
  logic [W-1:0]   base_a;
  logic [W-1:0]   base_b;
  logic [2*W-1:0] acc_a;
  logic [2*W-1:0] acc_b;

`ifdef LCM_ITER_COUNT_EN
  localparam logic [2*W-1:0] CNT_ONE = {{(2*W-1){1'b0}}, 1'b1};
`endif

  // Status flags come straight from the registered state, so there is no
  // combinational path from start/data_in to busy/done.
  assign busy = (state == LOADB) || (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      base_a <= '0;
      base_b <= '0;
      acc_a  <= '0;
      acc_b  <= '0;
      result <= '0;
`ifdef LCM_ITER_COUNT_EN
      iter_cnt <= '0;
`endif
    end else begin
      case (state)
        // IDLE and DONE both accept a new operand pair; DONE keeps result
        // visible until the new computation finishes.
        IDLE, DONE: begin
          if (start) begin
            base_a <= data_in;
            state  <= LOADB;
`ifdef LCM_ITER_COUNT_EN
            iter_cnt <= '0;
`endif
          end
        end

        LOADB: begin
          base_b <= data_in;
          acc_a  <= {ZERO_HI, base_a};
          acc_b  <= {ZERO_HI, data_in};
          // A zero operand short-circuits: the accumulators would never meet.
          if ((base_a == '0) || (data_in == '0)) begin
            result <= '0;
            state  <= DONE;
          end else begin
            state  <= RUN;
          end
        end

        RUN: begin
          // The smaller accumulator catches up by one multiple of its base;
          // the first common value is the LCM, bounded by A*B so no overflow.
          if (acc_a == acc_b) begin
            result <= acc_a;
            state  <= DONE;
          end else begin
            if (acc_a < acc_b) begin
              acc_a <= acc_a + {ZERO_HI, base_a};
            end else begin
              acc_b <= acc_b + {ZERO_HI, base_b};
            end
`ifdef LCM_ITER_COUNT_EN
            iter_cnt <= iter_cnt + CNT_ONE;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcm_add_seq.sv
module tb_lcm_add_seq;

  localparam int W      = 16;
  localparam int BUDGET = 2000;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   data_in;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
`ifdef LCM_ITER_COUNT_EN
  logic [2*W-1:0] iter_cnt;
`endif

  int checks = 0;
  int errors = 0;

  lcm_add_seq #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .result  (result)
`ifdef LCM_ITER_COUNT_EN
    ,
    .iter_cnt(iter_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_result;
    int             exp_edges;
    int             exp_iter;
    bit             noisy;     // wiggle start/data_in while RUN to prove they are ignored
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one operand pair from IDLE/DONE and wait for done.
  // Returns edges from the start-sampling edge to done, and cycles busy was high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy,
                        output int edges, output int busy_cnt);
    @(negedge clk);
    start   = 1'b1;
    data_in = a;
    @(negedge clk);
    start   = 1'b0;
    data_in = b;
    edges    = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < BUDGET) begin
      @(negedge clk);
      edges++;
      if (busy) busy_cnt++;
      if (noisy && !done) begin
        start   = 1'b1;
        data_in = '1;
      end
    end
    start   = 1'b0;
    data_in = '0;
  endtask

  initial begin
    int edges;
    int bcnt;

    //            a      b      result  edges iter  noisy
    vecs[0] = '{16'd4,   16'd6,   32'd12,    6,   3, 1'b0};
    vecs[1] = '{16'd7,   16'd7,   32'd7,     3,   0, 1'b1};
    vecs[2] = '{16'd255, 16'd256, 32'd65280, 512, 509, 1'b0};
    vecs[3] = '{16'd5,   16'd0,   32'd0,     2,   0, 1'b0};
    vecs[4] = '{16'd0,   16'd9,   32'd0,     2,   0, 1'b0};
    vecs[5] = '{16'd1,   16'd1,   32'd1,     3,   0, 1'b0};
    vecs[6] = '{16'd12,  16'd18,  32'd36,    6,   3, 1'b1};
    vecs[7] = '{16'd3,   16'd5,   32'd15,    9,   6, 1'b0};
    vecs[8] = '{16'd16,  16'd1,   32'd16,    18,  15, 1'b1};
    vecs[9] = '{16'd100, 16'd75,  32'd300,   8,   5, 1'b0};

    rst = 1'b1; start = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
`ifdef LCM_ITER_COUNT_EN
    check("reset_iter", iter_cnt, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("idle_hold_done", done, 0);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].noisy, edges, bcnt);
      check($sformatf("v%0d_done", i), done, 1);
      check($sformatf("v%0d_result", i), result, vecs[i].exp_result);
      check($sformatf("v%0d_latency", i), edges, vecs[i].exp_edges);
      check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].exp_edges - 1);
`ifdef LCM_ITER_COUNT_EN
      check($sformatf("v%0d_iter", i), iter_cnt, vecs[i].exp_iter);
`endif
      // DONE holds its result while start stays low
      @(negedge clk);
      check($sformatf("v%0d_hold", i), result, vecs[i].exp_result);
    end

    // Restart from DONE with result=12: done drops after one edge, result
    // stays 12 until the final edge, then becomes 36.
    run_op(16'd4, 16'd6, 1'b0, edges, bcnt);
    check("restart_pre_result", result, 12);
    @(negedge clk);
    start = 1'b1; data_in = 16'd9;
    @(negedge clk);
    start = 1'b0; data_in = 16'd12;
    check("restart_done_drop", done, 0);
    check("restart_busy", busy, 1);
    edges = 1;
    while (!done && edges < BUDGET) begin
      check($sformatf("restart_hold_e%0d", edges), result, 12);
      @(negedge clk);
      edges++;
    end
    check("restart_result", result, 36);
    check("restart_latency", edges, 8);

    // Reset on the third RUN cycle aborts the computation.
    @(negedge clk);
    start = 1'b1; data_in = 16'd4;
    @(negedge clk);
    start = 1'b0; data_in = 16'd6;      // edge1 -> LOADB
    @(negedge clk);                     // edge2 -> RUN (1st RUN cycle)
    @(negedge clk);                     // edge3 (2nd RUN cycle)
    @(negedge clk);                     // edge4 (3rd RUN cycle)
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    @(negedge clk);
    check("abort_stays_idle", busy, 0);
    run_op(16'd3, 16'd5, 1'b0, edges, bcnt);
    check("post_abort_result", result, 15);
    check("post_abort_latency", edges, 9);

    // rst and start together from DONE: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; data_in = 16'd8;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; data_in = '0;
    check("rst_wins_busy", busy, 0);
    check("rst_wins_done", done, 0);
    check("rst_wins_result", result, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
